// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
//   Bundles the hazard/redirect requests coming from the pipeline and the
//   PC-select / stall / flush controls going back to it.
//   Signal names are from the controller's point of view (i_ in, o_ out).
// Modports
//   master : pipeline side, drives the i_* requests and observes the o_* controls
//   slave  : controller side (pipeline_hazard_ctrl)
// Signals
//   i_halt, i_irq                : level requests
//   i_load_use_hazard            : decode reads rd of a load now in exec
//   i_jal_decode                 : valid JAL in decode
//   i_br_taken_exec, i_jalr_exec : exec-stage redirects
//   o_pc_sel[2:0]                : 0=pc+4 1=jal 2=branch 3=jalr 4=irq vector
//   o_stall_fetch, o_stall_decode, o_flush_decode, o_flush_exec
//   o_irq_ack                    : registered 1-cycle pulse on interrupt entry
//   o_halted                     : registered halted status
interface pipeline_hazard_ctrl_if;
  logic       i_halt;
  logic       i_irq;
  logic       i_load_use_hazard;
  logic       i_jal_decode;
  logic       i_br_taken_exec;
  logic       i_jalr_exec;
  logic [2:0] o_pc_sel;
  logic       o_stall_fetch;
  logic       o_stall_decode;
  logic       o_flush_decode;
  logic       o_flush_exec;
  logic       o_irq_ack;
  logic       o_halted;

  modport master (
    output i_halt, i_irq, i_load_use_hazard, i_jal_decode, i_br_taken_exec, i_jalr_exec,
    input  o_pc_sel, o_stall_fetch, o_stall_decode, o_flush_decode, o_flush_exec,
           o_irq_ack, o_halted
  );

  modport slave (
    input  i_halt, i_irq, i_load_use_hazard, i_jal_decode, i_br_taken_exec, i_jalr_exec,
    output o_pc_sel, o_stall_fetch, o_stall_decode, o_flush_decode, o_flush_exec,
           o_irq_ack, o_halted
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Central sequencer for the fetch/decode/exec pipeline: selects the next-PC
//   source and drives per-stage stall/flush for redirects, load-use bubbles,
//   halt and interrupt entry.
// Ports
//   i_clock : rising-edge clock
//   i_reset : asynchronous, active-high reset
//   bus     : pipeline_hazard_ctrl_if.slave (requests in, controls out)
// Parameters
//   LOAD_USE_STALL : bubble cycles per load-use hazard (1..7)
//   DRAIN_CYCLES   : cycles spent in IRQ_DRAIN before entry (1..15)
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_RUN       | normal issue; redirects, load-use stall start, jal, halt/irq
// S_LU_STALL  | remaining load-use bubble cycles after the first one
// S_HALTED    | front end frozen until halt drops
// S_IRQ_DRAIN | fetch held while exec work drains, DRAIN_CYCLES cycles
// S_IRQ_ENTER | one cycle redirect to the interrupt vector
module pipeline_hazard_ctrl #(
  parameter int unsigned LOAD_USE_STALL = 1,
  parameter int unsigned DRAIN_CYCLES   = 2
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  pipeline_hazard_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_RUN, S_LU_STALL, S_HALTED, S_IRQ_DRAIN, S_IRQ_ENTER
  } state_t;

  localparam logic [3:0] LU_LOAD    = 4'(LOAD_USE_STALL - 1);
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_irq_armed;
  logic       r_irq_ack;
  logic       r_halted;

  logic       w_redirect;
  logic [2:0] w_redir_sel;
  logic [2:0] w_pc_sel;
  logic       w_stall_fetch, w_stall_decode, w_flush_decode, w_flush_exec;

  // jalr outranks a same-cycle taken branch
  assign w_redirect  = bus.i_jalr_exec | bus.i_br_taken_exec;
  assign w_redir_sel = bus.i_jalr_exec ? 3'd3 : 3'd2;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_RUN;
      r_cnt       <= 4'd0;
      r_irq_armed <= 1'b1;
      r_irq_ack   <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_irq_ack <= (r_state == S_IRQ_ENTER);
      r_halted  <= (r_state == S_HALTED);
      // a held-high irq is taken once; re-arm only after it is seen low
      if (r_state == S_IRQ_ENTER)
        r_irq_armed <= 1'b0;
      else if (!bus.i_irq)
        r_irq_armed <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_pc_sel       = 3'd0;
    w_stall_fetch  = 1'b0;
    w_stall_decode = 1'b0;
    w_flush_decode = 1'b0;
    w_flush_exec   = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_redirect) begin
          // redirect also cancels a same-cycle load-use stall
          w_pc_sel       = w_redir_sel;
          w_flush_decode = 1'b1;
          w_flush_exec   = 1'b1;
        end else if (bus.i_load_use_hazard) begin
          w_stall_fetch  = 1'b1;
          w_stall_decode = 1'b1;
          w_flush_exec   = 1'b1;
          w_cnt_nxt      = LU_LOAD;
          if (LOAD_USE_STALL > 1) w_state_nxt = S_LU_STALL;
        end else if (bus.i_jal_decode) begin
          w_pc_sel       = 3'd1;
          w_flush_decode = 1'b1;
        end
        // an exec redirect defers halt/irq by one cycle; halt beats irq
        if (!w_redirect) begin
          if (bus.i_halt) begin
            w_state_nxt = S_HALTED;
          end else if (bus.i_irq && r_irq_armed) begin
            w_state_nxt = S_IRQ_DRAIN;
            w_cnt_nxt   = DRAIN_LOAD;
          end
        end
      end
      S_LU_STALL: begin
        if (w_redirect) begin
          w_pc_sel       = w_redir_sel;
          w_flush_decode = 1'b1;
          w_flush_exec   = 1'b1;
          w_cnt_nxt      = 4'd0;
          w_state_nxt    = S_RUN;
        end else begin
          w_stall_fetch  = 1'b1;
          w_stall_decode = 1'b1;
          w_flush_exec   = 1'b1;
          // the RUN cycle was the first bubble, so leave when this one empties the count
          if (r_cnt <= 4'd1) begin
            w_cnt_nxt   = 4'd0;
            w_state_nxt = S_RUN;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
      end
      S_HALTED: begin
        w_stall_fetch  = 1'b1;
        w_stall_decode = 1'b1;
        w_flush_exec   = 1'b1;
        if (!bus.i_halt) w_state_nxt = S_RUN;
      end
      S_IRQ_DRAIN: begin
        // exec redirects are ignored here; the handler restarts that instruction
        w_stall_fetch  = 1'b1;
        w_flush_decode = 1'b1;
        if (r_cnt == 4'd0) w_state_nxt = S_IRQ_ENTER;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_IRQ_ENTER: begin
        w_pc_sel       = 3'd4;
        w_flush_decode = 1'b1;
        w_flush_exec   = 1'b1;
        w_state_nxt    = S_RUN;
      end
      default: begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // hold the pipeline controls inactive while reset is asserted
  assign bus.o_pc_sel       = i_reset ? 3'd0 : w_pc_sel;
  assign bus.o_stall_fetch  = ~i_reset & w_stall_fetch;
  assign bus.o_stall_decode = ~i_reset & w_stall_decode;
  assign bus.o_flush_decode = ~i_reset & w_flush_decode;
  assign bus.o_flush_exec   = ~i_reset & w_flush_exec;
  assign bus.o_irq_ack      = r_irq_ack;
  assign bus.o_halted       = r_halted;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
  localparam int LUS = 2;
  localparam int DRN = 2;

  localparam int M_RUN   = 0;
  localparam int M_LU    = 1;
  localparam int M_HALT  = 2;
  localparam int M_DRAIN = 3;
  localparam int M_ENTER = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if bus();

  pipeline_hazard_ctrl #(
    .LOAD_USE_STALL(LUS),
    .DRAIN_CYCLES  (DRN)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [8:0] exp_q[$];

  // reference model: mode plus "cycles still to go" counts
  int m_mode, m_lu_left, m_drain_left;
  bit m_armed, m_ack, m_halted;

  function automatic logic [8:0] dut_vec();
    return {bus.o_pc_sel, bus.o_stall_fetch, bus.o_stall_decode,
            bus.o_flush_decode, bus.o_flush_exec, bus.o_irq_ack, bus.o_halted};
  endfunction

  task automatic model_reset();
    m_mode = M_RUN; m_lu_left = 0; m_drain_left = 0;
    m_armed = 1'b1; m_ack = 1'b0; m_halted = 1'b0;
  endtask

  task automatic model_step(input bit h, input bit ir, input bit lu, input bit jal,
                            input bit br, input bit jalr, output logic [8:0] e);
    int pc = 0;
    bit sf = 0, sd = 0, fd = 0, fe = 0;
    bit redir = br || jalr;
    int nmode = m_mode;
    bit e_ack = m_ack, e_halted = m_halted;
    case (m_mode)
      M_RUN: begin
        if (redir)      begin pc = jalr ? 3 : 2; fd = 1; fe = 1; end
        else if (lu)    begin sf = 1; sd = 1; fe = 1; end
        else if (jal)   begin pc = 1; fd = 1; end
        if (!redir && h) nmode = M_HALT;
        else if (!redir && ir && m_armed) begin nmode = M_DRAIN; m_drain_left = DRN; end
        else if (!redir && lu && LUS > 1) begin nmode = M_LU; m_lu_left = LUS - 1; end
      end
      M_LU: begin
        if (redir) begin pc = jalr ? 3 : 2; fd = 1; fe = 1; nmode = M_RUN; end
        else begin
          sf = 1; sd = 1; fe = 1;
          m_lu_left--;
          if (m_lu_left == 0) nmode = M_RUN;
        end
      end
      M_HALT: begin
        sf = 1; sd = 1; fe = 1;
        if (!h) nmode = M_RUN;
      end
      M_DRAIN: begin
        sf = 1; fd = 1;
        m_drain_left--;
        if (m_drain_left == 0) nmode = M_ENTER;
      end
      default: begin
        pc = 4; fd = 1; fe = 1; nmode = M_RUN;
      end
    endcase
    m_ack    = (m_mode == M_ENTER);
    m_halted = (m_mode == M_HALT);
    if (m_mode == M_ENTER) m_armed = 1'b0;
    else if (!ir)          m_armed = 1'b1;
    m_mode = nmode;
    e = {3'(pc), sf, sd, fd, fe, e_ack, e_halted};
  endtask

  task automatic apply(input bit h, input bit ir, input bit lu, input bit jal,
                       input bit br, input bit jalr);
    logic [8:0] e;
    @(posedge clk);
    #1;
    bus.i_halt = h; bus.i_irq = ir; bus.i_load_use_hazard = lu;
    bus.i_jal_decode = jal; bus.i_br_taken_exec = br; bus.i_jalr_exec = jalr;
    model_step(h, ir, lu, jal, br, jalr, e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply(0, 0, 0, 0, 0, 0);
  endtask

  task automatic direct_check(input string name, input logic [8:0] want);
    logic [8:0] got = dut_vec();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, got, want);
    end
  endtask

  // monitor: the DUT presents its controls every cycle; compare mid-cycle
  initial begin
    logic [8:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = dut_vec();
        checks++;
        cyc++;
        if (a !== e) begin
          errors++;
          $display("FAIL out_vec cyc=%0d actual=%b required=%b (pc_sel,sf,sd,fd,fe,ack,halted)",
                   cyc, a, e);
        end
      end
    end
  end

  initial begin
    bit h = 0, ir = 0;
    rst = 1'b1;
    bus.i_halt = 0; bus.i_irq = 0; bus.i_load_use_hazard = 0;
    bus.i_jal_decode = 0; bus.i_br_taken_exec = 0; bus.i_jalr_exec = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 direct_check("reset_state", 9'b0);
    @(negedge clk);
    rst = 1'b0;

    idle(2);
    // load-use with 2 bubbles, then normal flow
    apply(0, 0, 1, 0, 0, 0); idle(3);
    // redirect beats load-use; jalr beats branch
    apply(0, 0, 1, 0, 0, 1);
    apply(0, 0, 0, 0, 1, 1);
    apply(0, 0, 0, 0, 1, 0);
    idle(1);
    // jal held across a stall only redirects after it clears
    apply(0, 0, 1, 1, 0, 0); apply(0, 0, 0, 1, 0, 0); apply(0, 0, 0, 1, 0, 0);
    idle(1);
    // redirect inside LU_STALL
    apply(0, 0, 1, 0, 0, 0); apply(0, 0, 0, 0, 1, 0); idle(1);
    // halt with same-cycle branch defers the halt
    apply(1, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) apply(1, 0, 0, 0, 0, 0);
    idle(2);
    // irq held high: one entry only
    for (int k = 0; k < 10; k++) apply(0, 1, 0, 0, 0, 0);
    idle(2);
    for (int k = 0; k < 6; k++) apply(0, 1, 0, 0, 1, 0);
    idle(2);
    // halt and irq together: halt wins, irq taken after halt drops
    for (int k = 0; k < 4; k++) apply(1, 1, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) apply(0, 1, 0, 0, 0, 0);
    idle(2);

    // asynchronous reset in the middle of a load-use stall
    apply(0, 0, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    bus.i_load_use_hazard = 0;
    #1 direct_check("lu_stall_before_reset", 9'b000_1101_00);
    rst = 1'b1;
    #1 direct_check("async_reset_outputs", 9'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle(1);
    apply(0, 0, 0, 1, 0, 0);
    idle(1);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) < 4) h  = !h;
      if ($urandom_range(0, 99) < 8) ir = !ir;
      apply(h, ir,
            $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 8);
    end

    @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d left required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
